// File: rtl/cic_pkg.sv
// Shared sizing helpers and configuration limits for the CIC decimator.
package cic_pkg;

    localparam int MAX_N      = 6;
    localparam int MAX_R_LOG2 = 10;

    function automatic int cic_acc_width(input int iw, input int n, input int r_log2);
        return iw + n * r_log2;
    endfunction

    function automatic bit cic_n_ok(input int n);
        return (n >= 1) && (n <= MAX_N);
    endfunction

    function automatic bit cic_r_ok(input int r_log2);
        return (r_log2 >= 1) && (r_log2 <= MAX_R_LOG2);
    endfunction

    function automatic bit cic_cfg_ok(input int iw, input int ow, input int n, input int r_log2);
        return (iw >= 2) && (ow >= 2) && cic_n_ok(n) && cic_r_ok(r_log2);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One enabled wrap-around accumulator stage of the CIC integrator chain.
module cic_integrator
    import cic_pkg::*;
#(
    parameter int AW = 31
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic signed [AW-1:0] i_d,
    output logic signed [AW-1:0] o_q
);

    logic signed [AW-1:0] r_acc;

    // Wrap-around is intentional: the combs cancel it exactly.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + i_d;
        end
    end

    assign o_q = r_acc;

endmodule

// File: rtl/cic_decimator.sv
// Single-rail CIC decimator: N integrators at input rate, N unit-delay combs at
// rate 1/2^R_LOG2, output is the top OW bits of the AW-bit comb result.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IW     = 13,
    parameter int OW     = 16,
    parameter int N      = 3,
    parameter int R_LOG2 = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic signed [IW-1:0] i_data,
    input  logic                 i_valid,
    output logic signed [OW-1:0] o_data,
    output logic                 o_valid
);

    localparam int AW = cic_acc_width(IW, N, R_LOG2);

    if (!cic_cfg_ok(IW, OW, N, R_LOG2)) begin : g_cfg_err
        $error("cic_decimator: illegal configuration (N must be 1..6, R_LOG2 1..10)");
    end

    // Keep the top OW bits; for OW > AW this left-aligns with zero fill.
    function automatic logic signed [OW-1:0] scale_out(input logic signed [AW-1:0] v);
        logic [AW+OW-1:0] w_wide;
        w_wide = {v, {OW{1'b0}}};
        return w_wide[AW+OW-1 -: OW];
    endfunction

    logic signed [AW-1:0] w_ext;
    logic signed [AW-1:0] w_integ [N];

    assign w_ext = {{(AW-IW){i_data[IW-1]}}, i_data};

    for (genvar k = 0; k < N; k++) begin : g_integ
        if (k == 0) begin : g_first
            cic_integrator #(.AW(AW)) u_integ (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_en    (i_valid),
                .i_d     (w_ext),
                .o_q     (w_integ[k])
            );
        end else begin : g_next
            cic_integrator #(.AW(AW)) u_integ (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_en    (i_valid),
                .i_d     (w_integ[k-1]),
                .o_q     (w_integ[k])
            );
        end
    end

    logic [R_LOG2-1:0]    r_count;
    logic                 w_strobe;
    logic                 r_strobe_p1;
    logic signed [AW-1:0] r_cap_p1;

    assign w_strobe = i_valid && (r_count == {R_LOG2{1'b1}});

    // Stage p1: capture the last integrator on the decimation strobe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count     <= '0;
            r_strobe_p1 <= 1'b0;
            r_cap_p1    <= '0;
        end else begin
            r_strobe_p1 <= w_strobe;
            if (i_valid) begin
                r_count <= r_count + R_LOG2'(1);
            end
            if (w_strobe) begin
                r_cap_p1 <= w_integ[N-1];
            end
        end
    end

    logic signed [AW-1:0] r_dly [N];
    logic signed [AW-1:0] w_comb_in [N];
    logic signed [AW-1:0] w_comb_out;

    always_comb begin
        logic signed [AW-1:0] w_run;
        w_run = r_cap_p1;
        for (int k = 0; k < N; k++) begin
            w_comb_in[k] = w_run;
            w_run        = w_run - r_dly[k];
        end
        w_comb_out = w_run;
    end

    logic signed [OW-1:0] r_data_p2;
    logic                 r_valid_p2;

    // Stage p2: comb delays and the output word advance only on strobe_d.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N; k++) begin
                r_dly[k] <= '0;
            end
            r_data_p2  <= '0;
            r_valid_p2 <= 1'b0;
        end else begin
            r_valid_p2 <= r_strobe_p1;
            if (r_strobe_p1) begin
                for (int k = 0; k < N; k++) begin
                    r_dly[k] <= w_comb_in[k];
                end
                r_data_p2 <= scale_out(w_comb_out);
            end
        end
    end

    assign o_data  = r_data_p2;
    assign o_valid = r_valid_p2;

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Single-channel CIC decimation filter that sits directly downstream of the CORDIC mixer and consumes one of its output rails (I or Q).
- Instantiated twice, once per rail, in the SDR receive chain.
- Reduces sample rate by 2^R_LOG2 using N integrator stages at input rate and N comb stages (differential delay 1) at the decimated rate.
- Produces a scaled, truncated output with a one-cycle valid strobe per decimated sample.

Parameters:
IW, 13, input word width (matches CORDIC output width)
OW, 16, output word width
N, 3, number of integrator and comb stages (1..6)
R_LOG2, 6, log2 of the decimation ratio (R = 64)
AW, IW+N*R_LOG2 (derived, localparam), internal accumulator width, 31 at defaults

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_data  in  IW  signed input sample
i_valid  in  1  input sample qualifier; may be low arbitrarily, which stalls the filter
o_data  out  OW  signed decimated output
o_valid  out  1  one-cycle pulse when o_data is updated

Behaviour:
- Reset is asynchronous and active-high; no synchronous clear exists.
  - Clears all integrators, comb delays, the capture register, the decimation counter, o_data and o_valid to 0.
  - Reset asserted mid-operation aborts everything; the first output after release is computed from fresh state.
- Input sign-extension: i_data is sign-extended to AW bits.
- Integrators update only on cycles where i_valid=1 (Hogenauer pipeline):
  - integ[0] <= integ[0] + ext(i_data)
  - integ[k] <= integ[k] + integ[k-1] (pre-update value), k = 1..N-1
- Integrator arithmetic is AW-bit two's complement with silent wrap-around. This is required and correct; no saturation.
- Decimation counter:
  - R_LOG2 bits wide; increments on each i_valid and wraps from R-1 to 0.
  - A strobe fires on the cycle where i_valid=1 and count == R-1.
- Strobe cycle t:
  - cap <= integ[N-1] (pre-update value).
  - strobe_d <= 1; strobe_d is otherwise 0.
- Cycle t+1 (strobe_d=1), combs in one combinational chain:
  - c[0] = cap
  - c[k+1] = c[k] - dly[k]; dly[k] <= c[k]
  - All in AW-bit wrap-around arithmetic.
- Output register, updated at the end of cycle t+1:
  - o_data <= c[N][AW-1 : AW-OW], i.e. arithmetic shift right by AW-OW with truncation toward -inf.
  - If OW >= AW, c[N] is instead sign-extended and left-aligned.
- o_valid is 1 for exactly one cycle (cycle t+2) per strobe; o_data holds between strobes.
- Latency: o_valid is asserted 2 clocks after the strobe sampling edge.
- Gain: DC gain is R^N. At defaults, o_data steady state = x * 2^18 >> 15 = 8*x.
  - Full-scale -4096 gives -32768 and +4095 gives 32760; both fit OW=16.
- Stalls:
  - i_valid=0 during the strobe_d or output cycles does not disturb them; the comb path depends only on strobe_d.
  - Back-to-back strobes are impossible for R >= 2; R_LOG2 = 0 is illegal (elaboration assertion).

Decomposition:
- Package cic_pkg:
  - function cic_acc_width(iw, n, r_log2)
  - localparam limits MAX_N = 6, MAX_R_LOG2 = 10
  - elaboration-check helpers
- Sub-module cic_integrator: one enabled AW-bit accumulator stage, with inputs i_clk, i_reset, i_en, i_d and output o_q. It is generated N times; the combs stay inline.

Test Plan:
1. Reset defaults: reset held, random i_data/i_valid -> o_data=0, o_valid=0 throughout. After release with no i_valid, o_valid never rises.
2. DC response at defaults: i_data=1000, i_valid=1 continuous -> o_valid every 64 clocks. o_data=8000 from the (N+2)th output onward; earlier outputs rise monotonically.
3. Extremes: DC -4096 -> steady -32768. DC +4095 -> steady 32760. No wrap error is visible despite integrator wrap.
4. Stalled input: i_valid toggled pseudo-randomly at 30% duty with DC 500 -> exactly one o_valid per 64 accepted samples, o_valid width 1 clock, steady o_data=4000.
5. Small config (R_LOG2=2, N=3, AW=19): DC 7 -> o_valid every 4 valid inputs, steady o_data=56. Compare against a bit-exact reference model for random input over 10k samples.
6. Reset mid-stream: assert i_reset asynchronously between clock edges during the DC=1000 run -> outputs clear immediately. After release, the transient replays identically to scenario 2.
